inv_sbox_cipher: RTL and testbench



---
 rtl/inv_sbox_cipher.sv | 99 +++++++++
 tb/tb_inv_sbox_cipher.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/inv_sbox_cipher.sv
// Iterative decryption core for the 3-bit substitution cipher.
// Each RUN cycle applies one round: key XOR, then per-digit inverse substitution.
module inv_sbox_cipher #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned ROUNDS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3*NIBBLES-1:0]   in_data,
  input  logic [3*NIBBLES-1:0]   key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3*NIBBLES-1:0]   out_data,
  output logic                   busy
);

  localparam int unsigned W    = 3 * NIBBLES;
  localparam int unsigned CntW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [W-1:0]    state_q, state_d;
  logic [W-1:0]    key_q, key_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    mix;
  logic [W-1:0]    round_out;

  function automatic logic [2:0] inv_sub(input logic [2:0] d);
    logic [2:0] r;
    case (d)
      3'd0:    r = 3'd0;
      3'd1:    r = 3'd6;
      3'd2:    r = 3'd7;
      3'd3:    r = 3'd5;
      3'd4:    r = 3'd4;
      3'd5:    r = 3'd1;
      3'd6:    r = 3'd2;
      default: r = 3'd3;
    endcase
    return r;
  endfunction

  always_comb begin
    mix       = state_q ^ key_q;
    round_out = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      round_out[3*i +: 3] = inv_sub(mix[3*i +: 3]);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    unique case (fsm_q)
      StIdle: begin
        if (in_valid) begin
          state_d = in_data;
          key_d   = key;
          cnt_d   = '0;
          fsm_d   = StRun;
        end
      end
      StRun: begin
        state_d = round_out;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ROUNDS - 1)) fsm_d = StDone;
      end
      StDone: begin
        if (out_ready) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (fsm_q == StIdle);
  assign out_valid = (fsm_q == StDone);
  assign busy      = (fsm_q == StRun) || (fsm_q == StDone);
  assign out_data  = state_q;

endmodule

// File: tb/tb_inv_sbox_cipher.sv
// Bench for inv_sbox_cipher: three instances (ROUNDS 1, 2, 4) checked against
// a table-driven cipher model, with backpressure and mid-run reset.
module tb_inv_sbox_cipher;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [NDUT];
  logic        in_ready  [NDUT];
  logic [11:0] in_data   [NDUT];
  logic [11:0] key       [NDUT];
  logic        out_valid [NDUT];
  logic        out_ready [NDUT];
  logic [11:0] out_data  [NDUT];
  logic        busy      [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned R = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    inv_sbox_cipher #(.NIBBLES(4), .ROUNDS(R)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .key       (key[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  function automatic int rounds_of(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 2 : 4;
  endfunction

  // Forward cipher: rounds of s = sbox(s) ^ key.
  function automatic int encrypt(input int pt, input int k, input int rounds);
    int fwd [8] = '{0, 5, 6, 7, 4, 3, 1, 2};
    int s = pt;
    for (int r = 0; r < rounds; r++) begin
      int n = 0;
      for (int i = 0; i < 4; i++) n |= fwd[(s >> (3 * i)) & 7] << (3 * i);
      s = n ^ k;
    end
    return s;
  endfunction

  function automatic int decrypt(input int ct, input int k, input int rounds);
    int inv [8] = '{0, 6, 7, 5, 4, 1, 2, 3};
    int s = ct;
    for (int r = 0; r < rounds; r++) begin
      int n = 0;
      s = s ^ k;
      for (int i = 0; i < 4; i++) n |= inv[(s >> (3 * i)) & 7] << (3 * i);
      s = n;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one block at a negedge; hold > 0 keeps out_ready low that many cycles.
  task automatic run_block(input int idx, input logic [11:0] ct, input logic [11:0] k,
                           input logic [11:0] exp, input int hold);
    int lat;
    out_ready[idx] = (hold == 0);
    in_valid[idx]  = 1'b1;
    in_data[idx]   = ct;
    key[idx]       = k;
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    in_data[idx]  = 12'($urandom);
    key[idx]      = 12'($urandom);
    check("ready_low_after_accept", in_ready[idx], 1'b0);
    lat = 0;
    while (!out_valid[idx] && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      key[idx] = 12'($urandom);
    end
    check("latency", lat, rounds_of(idx));
    check("out_data", out_data[idx], exp);
    for (int c = 0; c < hold; c++) begin
      in_valid[idx] = ~in_valid[idx];
      in_data[idx]  = 12'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_in_ready", in_ready[idx], 1'b0);
      check("bp_out_valid", out_valid[idx], 1'b1);
      check("bp_out_data", out_data[idx], exp);
    end
    in_valid[idx]  = 1'b0;
    out_ready[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("valid_drop", out_valid[idx], 1'b0);
    check("ready_back", in_ready[idx], 1'b1);
    check("idle_busy", busy[idx], 1'b0);
  endtask

  initial begin
    logic [11:0] pt, k, ct;
    for (int i = 0; i < NDUT; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      key[i]       = '0;
      out_ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < NDUT; i++) begin
      check("rst_in_ready", in_ready[i], 1'b1);
      check("rst_out_valid", out_valid[i], 1'b0);
      check("rst_busy", busy[i], 1'b0);
      check("rst_out_data", out_data[i], 12'o0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_block(0, 12'o7654, 12'o0000, 12'o3214, 0);
    run_block(0, 12'o0000, 12'o7777, 12'o3333, 0);
    run_block(1, 12'o0001, 12'o0000, 12'o0002, 0);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 2; i++) begin
        ct = 12'($urandom);
        k  = 12'($urandom);
        run_block(i, ct, k, 12'(decrypt(int'(ct), int'(k), rounds_of(i))), 0);
      end
    end

    for (int n = 0; n < 1000; n++) begin
      pt = 12'($urandom);
      k  = 12'($urandom);
      ct = 12'(encrypt(int'(pt), int'(k), 4));
      run_block(2, ct, k, pt, 0);
    end

    pt = 12'($urandom);
    k  = 12'($urandom);
    run_block(2, 12'(encrypt(int'(pt), int'(k), 4)), k, pt, 10);

    // Reset after two rounds, between clock edges.
    in_valid[2] = 1'b1;
    in_data[2]  = 12'o1234;
    key[2]      = 12'o4321;
    @(posedge clk);
    #1 in_valid[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid[2], 1'b0);
    check("mid_rst_in_ready", in_ready[2], 1'b1);
    check("mid_rst_out_data", out_data[2], 12'o0000);
    check("mid_rst_busy", busy[2], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_valid", out_valid[2], 1'b0);
    pt = 12'($urandom);
    k  = 12'($urandom);
    run_block(2, 12'(encrypt(int'(pt), int'(k), 4)), k, pt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
